// File: rtl/ddr4_pkg.sv
// ddr4_pkg: shared types, address-map bit positions and default timings for the DDR4 command issuer
package ddr4_pkg;
  localparam int ROW_HI = 32;
  localparam int ROW_LO = 18;
  localparam int HCOL_HI = 17;
  localparam int HCOL_LO = 10;
  localparam int BANK_HI = 9;
  localparam int BANK_LO = 8;
  localparam int BG_HI = 7;
  localparam int BG_LO = 6;
  localparam int LCOL_HI = 5;
  localparam int LCOL_LO = 3;
  localparam int unsigned DEF_T_RCD = 24;
  localparam int unsigned DEF_T_RAS = 52;
  localparam int unsigned DEF_T_RTP = 12;
  localparam int unsigned DEF_T_CWL = 20;
  localparam int unsigned DEF_T_BURST = 4;
  localparam int unsigned DEF_T_WR = 20;
  localparam int unsigned DEF_T_RP = 24;
  localparam int unsigned DEF_CNT_W = 8;
  typedef logic [ROW_HI-ROW_LO:0] row_t;
  typedef logic [HCOL_HI-HCOL_LO+LCOL_HI-LCOL_LO+1:0] col_t;
  typedef logic [BANK_HI-BANK_LO:0] bank_t;
  typedef logic [BG_HI-BG_LO:0] bg_t;
  typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE} cmd_e;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_IF, OP_ILL} op_e;
  typedef enum logic [2:0] {ST_IDLE, ST_ACT, ST_WAIT_RCD, ST_COL, ST_WAIT_PRE, ST_PRE, ST_WAIT_RP} state_e;
  typedef struct packed {
    row_t row;
    col_t col;
    bank_t bank;
    bg_t bg;
  } fields_t;
endpackage

// File: rtl/ddr4_cmd_issuer_if.sv
// ddr4_cmd_issuer_if: request handshake from the trace queue and DDR4 command output bundle
interface ddr4_cmd_issuer_if;
  import ddr4_pkg::*;
  logic req_valid_i;
  logic req_ready_o;
  logic [1:0] req_op_i;
  logic [32:0] req_addr_i;
  logic cmd_valid_o;
  cmd_e cmd_o;
  bg_t cmd_bg_o;
  bank_t cmd_bank_o;
  row_t cmd_row_o;
  col_t cmd_col_o;
  logic done_o;
  logic err_o;
  modport master (
    output req_valid_i, req_op_i, req_addr_i,
    input req_ready_o, cmd_valid_o, cmd_o, cmd_bg_o, cmd_bank_o, cmd_row_o, cmd_col_o, done_o, err_o
  );
  modport slave (
    input req_valid_i, req_op_i, req_addr_i,
    output req_ready_o, cmd_valid_o, cmd_o, cmd_bg_o, cmd_bank_o, cmd_row_o, cmd_col_o, done_o, err_o
  );
endinterface

// File: rtl/ddr4_addr_decode.sv
// ddr4_addr_decode: splits a byte address into row/column/bank/bank-group fields
module ddr4_addr_decode
  import ddr4_pkg::*;
(
  input  logic [32:0] addr_i,
  output fields_t     fields_o
);
  logic unused_lsb;
  assign unused_lsb = ^addr_i[2:0];
  assign fields_o.row = addr_i[ROW_HI:ROW_LO];
  assign fields_o.col = {addr_i[HCOL_HI:HCOL_LO], addr_i[LCOL_HI:LCOL_LO]};
  assign fields_o.bank = addr_i[BANK_HI:BANK_LO];
  assign fields_o.bg = addr_i[BG_HI:BG_LO];
endmodule

// File: rtl/ddr4_cmd_issuer.sv
// ddr4_cmd_issuer: serves one request at a time as a closed-page ACT -> RD/WR -> PRE sequence
module ddr4_cmd_issuer
  import ddr4_pkg::*;
#(
  parameter int unsigned T_RCD = DEF_T_RCD,
  parameter int unsigned T_RAS = DEF_T_RAS,
  parameter int unsigned T_RTP = DEF_T_RTP,
  parameter int unsigned T_CWL = DEF_T_CWL,
  parameter int unsigned T_BURST = DEF_T_BURST,
  parameter int unsigned T_WR = DEF_T_WR,
  parameter int unsigned T_RP = DEF_T_RP,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic reset,
  ddr4_cmd_issuer_if.slave bus
);
  if (T_RCD >= 2**CNT_W || T_RAS >= 2**CNT_W || T_RTP >= 2**CNT_W || T_RP >= 2**CNT_W ||
      T_CWL + T_BURST + T_WR >= 2**CNT_W) begin : g_cnt_w_check
    $error("ddr4_cmd_issuer: timing value does not fit in CNT_W bits");
  end
  localparam logic [CNT_W-1:0] L_RCD = CNT_W'(T_RCD);
  localparam logic [CNT_W-1:0] L_RAS = CNT_W'(T_RAS);
  localparam logic [CNT_W-1:0] L_RTP = CNT_W'(T_RTP);
  localparam logic [CNT_W-1:0] L_WRP = CNT_W'(T_CWL + T_BURST + T_WR);
  localparam logic [CNT_W-1:0] L_RP = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_e state_q, state_d;
  op_e op_q, op_d;
  fields_t fld_q, fld_d, dec;
  logic [CNT_W-1:0] cnt_q, cnt_d, ras_q, ras_d;
  cmd_e cmd_q, cmd_d;
  logic ready_q, ready_d, valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic accept;
  assign accept = bus.req_valid_i && ready_q;
  ddr4_addr_decode u_decode (.addr_i(bus.req_addr_i), .fields_o(dec));
  // state, timers, captured request and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q <= OP_RD;
      fld_q <= '0;
      cnt_q <= '0;
      ras_q <= '0;
      cmd_q <= CMD_NOP;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      fld_q <= fld_d;
      cnt_q <= cnt_d;
      ras_q <= ras_d;
      cmd_q <= cmd_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  // next state: each wait ends when its timer is about to expire so the next command lands on time
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = accept ? ST_ACT : ST_IDLE;
      ST_ACT, ST_WAIT_RCD: state_d = cnt_q <= ONE ? ST_COL : ST_WAIT_RCD;
      ST_COL, ST_WAIT_PRE: state_d = (cnt_q <= ONE && ras_q <= ONE) ? ST_PRE : ST_WAIT_PRE;
      ST_PRE, ST_WAIT_RP: state_d = cnt_q <= ONE ? ST_IDLE : ST_WAIT_RP;
      default: state_d = ST_IDLE;
    endcase
  end
  // outputs and timers computed from the upcoming state so every output is a flop
  always_comb begin
    op_d = accept ? op_e'(bus.req_op_i) : op_q;
    fld_d = accept ? dec : fld_q;
    cnt_d = state_d == ST_ACT ? L_RCD :
            state_d == ST_COL ? (op_q == OP_WR ? L_WRP : L_RTP) :
            state_d == ST_PRE ? L_RP :
            cnt_q == '0 ? '0 : cnt_q - ONE;
    ras_d = state_d == ST_ACT ? L_RAS : ras_q == '0 ? '0 : ras_q - ONE;
    cmd_d = state_d == ST_ACT ? CMD_ACT :
            state_d == ST_COL ? (op_q == OP_WR ? CMD_WR : CMD_RD) :
            state_d == ST_PRE ? CMD_PRE : CMD_NOP;
    valid_d = cmd_d != CMD_NOP;
    ready_d = state_d == ST_IDLE;
    done_d = (state_q == ST_PRE || state_q == ST_WAIT_RP) && state_d == ST_IDLE;
    err_d = state_d == ST_ACT && op_d == OP_ILL;
  end
  assign bus.req_ready_o = ready_q;
  assign bus.cmd_valid_o = valid_q;
  assign bus.cmd_o = cmd_q;
  assign bus.cmd_bg_o = fld_q.bg;
  assign bus.cmd_bank_o = fld_q.bank;
  assign bus.cmd_row_o = fld_q.row;
  assign bus.cmd_col_o = fld_q.col;
  assign bus.done_o = done_q;
  assign bus.err_o = err_q;
endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// tb_ddr4_cmd_issuer: directed requests against a default issuer and a short-tRAS issuer, checked by an event-time model
module tb_ddr4_cmd_issuer;
  import ddr4_pkg::*;
  localparam int RCD = 24, RTP = 12, CWL = 20, BURST = 4, WRR = 20, RP = 24;
  localparam int RAS0 = 52, RAS1 = 10;
  localparam logic [32:0] ADDR = 33'h0_0014_4A58;
  localparam logic [32:0] ADDR2 = 33'h1_2345_6788;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  ddr4_cmd_issuer_if b0();
  ddr4_cmd_issuer_if b1();
  assign b1.req_valid_i = b0.req_valid_i;
  assign b1.req_op_i = b0.req_op_i;
  assign b1.req_addr_i = b0.req_addr_i;
  ddr4_cmd_issuer u0 (.clk(clk), .reset(reset), .bus(b0));
  ddr4_cmd_issuer #(.T_RAS(RAS1), .T_RTP(RTP)) u1 (.clk(clk), .reset(reset), .bus(b1));
  logic [1:0] rdy, vld, dn, er;
  logic [2:0] cmd [2];
  logic [29:0] fld [2];
  assign rdy = {b1.req_ready_o, b0.req_ready_o};
  assign vld = {b1.cmd_valid_o, b0.cmd_valid_o};
  assign dn = {b1.done_o, b0.done_o};
  assign er = {b1.err_o, b0.err_o};
  assign cmd[0] = b0.cmd_o;
  assign cmd[1] = b1.cmd_o;
  assign fld[0] = {b0.cmd_row_o, b0.cmd_col_o, b0.cmd_bank_o, b0.cmd_bg_o};
  assign fld[1] = {b1.cmd_row_o, b1.cmd_col_o, b1.cmd_bank_o, b1.cmd_bg_o};
  int total = 0, bad = 0, cyc = 0;
  bit live = 0;
  int mA [2], mC [2], mP [2], mD [2], mop [2];
  logic [29:0] mfld [2];
  int lastA [2] = '{-1, -1}, prevA [2] = '{-1, -1}, lastC [2] = '{-1, -1};
  int lastP [2] = '{-1, -1}, lastD [2] = '{-1, -1}, lastE [2] = '{-1, -1};
  logic [2:0] colCmd [2];
  logic [29:0] actFld [2], preFld [2];
  // model: on each accepted request, schedule the absolute cycles of ACT, RD/WR, PRE and done
  always @(posedge clk) begin
    int ras, c, p;
    logic [32:0] a;
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mA[i] = -1000; mC[i] = -1000; mP[i] = -1000; mD[i] = -1000;
        mop[i] = 0; mfld[i] = '0; live = 1;
      end else if (b0.req_valid_i && cyc - 1 >= mD[i]) begin
        ras = i == 0 ? RAS0 : RAS1;
        a = b0.req_addr_i;
        mop[i] = int'(b0.req_op_i);
        mA[i] = cyc;
        c = cyc + RCD;
        p = c + (mop[i] == 1 ? CWL + BURST + WRR : RTP);
        if (cyc + ras > p) p = cyc + ras;
        mC[i] = c; mP[i] = p; mD[i] = p + RP;
        mfld[i] = {a[32:18], a[17:10], a[5:3], a[9:8], a[7:6]};
      end
    end
  end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (live) begin
      for (int i = 0; i < 2; i++) begin
        int n;
        logic [2:0] ec;
        n = cyc;
        ec = n == mA[i] ? CMD_ACT : n == mC[i] ? (mop[i] == 1 ? CMD_WR : CMD_RD) : n == mP[i] ? CMD_PRE : CMD_NOP;
        chk($sformatf("cyc%0d inst%0d {ready,valid,cmd,fields,done,err}", n, i),
            64'({rdy[i], vld[i], cmd[i], fld[i], dn[i], er[i]}),
            64'({n >= mD[i], ec != CMD_NOP, ec, mfld[i], n == mD[i], n == mA[i] && mop[i] == 3}));
        if (vld[i]) begin
          if (cmd[i] == CMD_ACT) begin prevA[i] = lastA[i]; lastA[i] = n; actFld[i] = fld[i]; end
          if (cmd[i] == CMD_RD || cmd[i] == CMD_WR) begin lastC[i] = n; colCmd[i] = cmd[i]; end
          if (cmd[i] == CMD_PRE) begin lastP[i] = n; preFld[i] = fld[i]; end
        end
        if (dn[i]) lastD[i] = n;
        if (er[i]) lastE[i] = n;
      end
    end
  endtask
  task automatic cycles(int k);
    repeat (k) tick();
  endtask
  task automatic go(logic [1:0] op, logic [32:0] a, output int v);
    b0.req_valid_i = 1'b1;
    b0.req_op_i = op;
    b0.req_addr_i = a;
    v = cyc;
    tick();
    b0.req_valid_i = 1'b0;
  endtask
  initial begin
    int v;
    reset = 1'b1;
    b0.req_valid_i = 1'b0;
    b0.req_op_i = 2'd0;
    b0.req_addr_i = '0;
    cycles(3);
    reset = 1'b0;
    cycles(6);
    chk("reset ready", 64'(rdy[0]), 64'(1));
    chk("reset cmd_valid", 64'(vld[0]), 64'(0));
    chk("reset fields", 64'(fld[0]), 64'(0));
    go(2'd0, ADDR, v);
    cycles(110);
    chk("read ACT offset", 64'(lastA[0] - v), 64'(1));
    chk("read RD offset", 64'(lastC[0] - v), 64'(25));
    chk("read PRE offset", 64'(lastP[0] - v), 64'(53));
    chk("read done offset", 64'(lastD[0] - v), 64'(77));
    chk("read col cmd", 64'(colCmd[0]), 64'(CMD_RD));
    chk("read ACT fields", 64'(actFld[0]), 64'({15'd5, 11'h093, 2'd2, 2'd1}));
    go(2'd1, ADDR, v);
    cycles(120);
    chk("write col cmd", 64'(colCmd[0]), 64'(CMD_WR));
    chk("write WR offset", 64'(lastC[0] - v), 64'(25));
    chk("write PRE offset", 64'(lastP[0] - v), 64'(69));
    chk("write done offset", 64'(lastD[0] - v), 64'(93));
    b0.req_valid_i = 1'b1;
    b0.req_op_i = 2'd0;
    b0.req_addr_i = ADDR;
    v = cyc;
    tick();
    b0.req_op_i = 2'd2;
    b0.req_addr_i = ADDR2;
    cycles(77);
    b0.req_valid_i = 1'b0;
    cycles(130);
    chk("b2b ACT spacing", 64'(lastA[0] - prevA[0]), 64'(77));
    chk("b2b second done offset", 64'(lastD[0] - v), 64'(154));
    chk("b2b ifetch col cmd", 64'(colCmd[0]), 64'(CMD_RD));
    chk("b2b second fields", 64'(actFld[0]), 64'({15'h48D1, 11'h2C9, 2'd3, 2'd2}));
    go(2'd3, ADDR, v);
    cycles(110);
    chk("illegal err with ACT", 64'(lastE[0] - v), 64'(1));
    chk("illegal ACT offset", 64'(lastA[0] - v), 64'(1));
    chk("illegal col cmd", 64'(colCmd[0]), 64'(CMD_RD));
    chk("illegal done offset", 64'(lastD[0] - v), 64'(77));
    go(2'd0, ADDR, v);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid reset ready", 64'(rdy[0]), 64'(1));
    chk("mid reset cmd_valid", 64'(vld[0]), 64'(0));
    cycles(110);
    chk("mid reset no RD", 64'(lastC[0] < v), 64'(1));
    chk("mid reset no PRE", 64'(lastP[0] < v), 64'(1));
    chk("mid reset no done", 64'(lastD[0] < v), 64'(1));
    go(2'd0, ADDR, v);
    b0.req_addr_i = ADDR2;
    cycles(110);
    chk("short tRAS RD offset", 64'(lastC[1] - v), 64'(25));
    chk("short tRAS PRE after RD", 64'(lastP[1] - lastC[1]), 64'(12));
    chk("short tRAS done offset", 64'(lastD[1] - v), 64'(61));
    chk("short tRAS fields held", 64'(preFld[1]), 64'({15'd5, 11'h093, 2'd2, 2'd1}));
    chk("default fields held", 64'(preFld[0]), 64'({15'd5, 11'h093, 2'd2, 2'd1}));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
